// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types, defaults and request decode for the PC sequencer
//
// Purpose : common definitions imported by pc_sequencer and pc_ras.
// Contents: op_t request enum, default parameter constants, and
//           pc_decode(), which resolves simultaneous requests into one
//           operation (ret over call over branch over sequential).
//           Stall and reset are resolved in the top level ahead of decode.
package pc_seq_pkg;

    localparam int unsigned DEF_WIDTH       = 32;
    localparam int unsigned DEF_INC         = 4;
    localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0100;

    typedef enum logic [1:0] {
        OP_SEQ    = 2'd0,
        OP_BRANCH = 2'd1,
        OP_CALL   = 2'd2,
        OP_RET    = 2'd3
    } op_t;

    // A losing request is simply dropped; whether that drop is an error
    // (ret+call) or silent (branch under call/ret) is decided by the caller.
    function automatic op_t pc_decode(
        input logic ret,
        input logic call,
        input logic branch
    );
        op_t op;
        if (ret) begin
            op = OP_RET;
        end else if (call) begin
            op = OP_CALL;
        end else if (branch) begin
            op = OP_BRANCH;
        end else begin
            op = OP_SEQ;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack
//
// Purpose : LIFO of return addresses with a wrapping top pointer. When the
//           stack is full a push overwrites the oldest entry and the count
//           stays saturated at DEPTH.
// Ports   : clk        - clock, rising edge
//           reset      - synchronous active-high reset (clears ptr/count)
//           push       - write push_data as the new top
//           pop        - discard the top entry (ignored when empty)
//           push_data  - address to push
//           top        - current top entry (meaningful when not empty)
//           count      - number of valid entries, 0..DEPTH
//           empty/full - status decoded from count
import pc_seq_pkg::*;

module pc_ras #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    // ptr names the next free slot; the top entry sits one below it.
    // Because DEPTH is a power of two the pointer wraps naturally, and a
    // push while full lands exactly on the oldest entry.
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && !empty;
    assign do_push = push && !do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign top   = mem[ptr - PTR_ONE];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_pop) begin
            ptr   <= ptr - PTR_ONE;
            count <= count - CNT_ONE;
        end else if (do_push) begin
            ptr <= ptr + PTR_ONE;
            if (!full) begin
                count <= count + CNT_ONE;
            end
        end
    end

    // Entry storage is not reset; a zero count is what makes entries invalid.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with return-address stack
//
// Purpose : registered PC with sequential advance, branch, call and return.
//           Priority: reset, stall, ret, call, branch, sequential.
// Ports   : clk        - clock, rising edge
//           reset      - synchronous active-high reset
//           stall      - hold pc/stack, ignore requests
//           branch     - pc <= target
//           call       - push pc+INC, pc <= target
//           ret        - pc <= popped return address
//           target     - branch/call destination
//           pc         - current program counter (registered)
//           ras_count  - valid stack entries
//           ras_empty  - ras_count == 0
//           ras_full   - ras_count == RAS_DEPTH
//           err        - registered one-cycle pulse on an illegal operation
// Options : PC_SEQ_TRAP_EN - misaligned redirect destinations load TRAP_VECTOR
//           and pulse err; a call still pushes its return address.
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               INC          = DEF_INC,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEF_TRAP_VECTOR)
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           target,
    output logic [WIDTH-1:0]           pc,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       err
);

    op_t              op;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] dest;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;
    logic             err_next;

    assign op     = pc_decode(ret, call, branch);
    assign seq_pc = pc + WIDTH'(INC);

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Operation decode: chooses the destination and the stack action.
    // A ret on an empty stack falls through to the sequential address.
    always_comb begin
        dest     = seq_pc;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        err_next = 1'b0;
        if (!stall) begin
            case (op)
                OP_RET: begin
                    // call lost arbitration to ret: flag it
                    err_next = call;
                    if (!ras_empty) begin
                        dest    = ras_top;
                        ras_pop = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                OP_CALL: begin
                    dest     = target;
                    ras_push = 1'b1;
                end
                OP_BRANCH: begin
                    dest = target;
                end
                default: begin
                    dest = seq_pc;
                end
            endcase
        end
    end

`ifdef PC_SEQ_TRAP_EN
    // Only real redirects are alignment-checked; the sequential fallback of
    // an empty ret is not a destination supplied by software.
    logic redirect;
    logic misaligned;

    assign redirect   = !stall && ((op == OP_BRANCH) || (op == OP_CALL) ||
                                   ((op == OP_RET) && !ras_empty));
    assign misaligned = redirect && (dest[1:0] != 2'b00);

    always_comb begin
        if (stall) begin
            next_pc = pc;
        end else if (misaligned) begin
            next_pc = TRAP_VECTOR;
        end else begin
            next_pc = dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= err_next || misaligned;
        end
    end
`else
    always_comb begin
        if (stall) begin
            next_pc = pc;
        end else begin
            next_pc = dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (directed + random)
module tb_pc_sequencer;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [2:0]   cnt;
        logic         err;
        logic         empty;
        logic         full;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic         branch = 1'b0;
    logic         call = 1'b0;
    logic         ret = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] pc;
    logic [2:0]   ras_count;
    logic         ras_empty;
    logic         ras_full;
    logic         err;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH        (W),
        .INC          (4),
        .RESET_VECTOR (16'h0000),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .pc        (pc),
        .ras_count (ras_count),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .err       (err)
    );

    // Reference model: plain queue of return addresses, newest at the back.
    logic [W-1:0] m_pc;
    logic         m_err;
    logic [W-1:0] stk[$];
    obs_t         exp_q[$];
    int           checks = 0;
    int           passed = 0;
    int           cyc = 0;

    task automatic model(input logic r, input logic s, input logic c,
                         input logic rt, input logic b, input logic [W-1:0] t);
        logic [W-1:0] d;
        logic         redir;
        obs_t         e;
        redir = 1'b0;
        d     = m_pc + 16'd4;
        if (r) begin
            m_pc  = 16'h0000;
            m_err = 1'b0;
            stk.delete();
        end else if (s) begin
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (rt) begin
                if (c) m_err = 1'b1;
                if (stk.size() > 0) begin
                    d     = stk.pop_back();
                    redir = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end else if (c) begin
                stk.push_back(m_pc + 16'd4);
                if (stk.size() > DEPTH) void'(stk.pop_front());
                d     = t;
                redir = 1'b1;
            end else if (b) begin
                d     = t;
                redir = 1'b1;
            end
`ifdef PC_SEQ_TRAP_EN
            if (redir && (d % 4 != 0)) begin
                d     = 16'h0100;
                m_err = 1'b1;
            end
`endif
            m_pc = d;
        end
        e.pc    = m_pc;
        e.cnt   = 3'(stk.size());
        e.err   = m_err;
        e.empty = (stk.size() == 0);
        e.full  = (stk.size() == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic c,
                        input logic rt, input logic b, input logic [W-1:0] t);
        reset = r; stall = s; call = c; ret = rt; branch = b; target = t;
        @(posedge clk);
        model(r, s, c, rt, b, t);
        #1;
    endtask

    // Monitor: every cycle presents a result; compare it on the falling edge.
    always @(negedge clk) begin
        obs_t e;
        obs_t got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{pc: pc, cnt: ras_count, err: err, empty: ras_empty, full: ras_full};
            checks++;
            cyc++;
            if (got !== e)
                $display("FAIL step%0d: pc=%h cnt=%0d err=%b empty=%b full=%b, want pc=%h cnt=%0d err=%b empty=%b full=%b",
                         cyc, got.pc, got.cnt, got.err, got.empty, got.full,
                         e.pc, e.cnt, e.err, e.empty, e.full);
            else
                passed++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r, s, c, rt, b;
        logic [W-1:0] t;
        m_pc  = '0;
        m_err = 1'b0;

        // reset, then free-running sequential: 0, 4, 8, 12
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // call/return round trip from 0x10
        step(0, 0, 0, 0, 1, 16'h0010);
        step(0, 0, 1, 0, 0, 16'h0100);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // overflow the stack, then unwind past empty
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 16'h0200 + 16'(i * 16));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);

        // stall with toggling requests (one entry on the stack)
        step(0, 0, 1, 0, 0, 16'h0300);
        step(0, 1, 1, 0, 0, 16'h0400);
        step(0, 1, 0, 1, 1, 16'h0500);
        step(0, 1, 1, 1, 1, 16'h0600);
        step(0, 0, 0, 0, 0, 0);

        // 16-bit wrap and ret+call collision
        step(0, 0, 0, 0, 1, 16'hFFFC);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 16'h0700);
        step(0, 0, 1, 1, 1, 16'h0800);

        // branch under call is silently ignored
        step(0, 0, 1, 0, 1, 16'h0900);
        step(0, 0, 0, 1, 1, 16'h0A00);

        // misaligned branch
        step(0, 0, 0, 0, 1, 16'h0102);
        step(0, 0, 0, 0, 0, 0);

        // reset during a ret with a partly full stack
        step(0, 0, 1, 0, 0, 16'h0B00);
        step(0, 0, 1, 0, 0, 16'h0C00);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 3) == 0);
            rt = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 3) == 0);
            t  = 16'($urandom);
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            step(r, s, c, rt, b, t);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
